// File: rtl/wordle_pkg.sv
// Shared types, score encodings and ASCII helpers for the Wordle engine.
// Imported by the top-level FSM and by the scoring datapath.
package wordle_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_SCORE_G = 3'd2,
        ST_SCORE_Y = 3'd3,
        ST_RESULT  = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    localparam logic [1:0] SC_ABSENT = 2'b00;
    localparam logic [1:0] SC_YELLOW = 2'b01;
    localparam logic [1:0] SC_GREEN  = 2'b10;

    localparam logic [7:0] ASCII_UC_A     = 8'h41;
    localparam logic [7:0] ASCII_UC_Z     = 8'h5A;
    localparam logic [7:0] ASCII_LC_A     = 8'h61;
    localparam logic [7:0] ASCII_LC_Z     = 8'h7A;
    localparam logic [7:0] ASCII_CASE_OFS = 8'h20;

    function automatic logic [7:0] fold_upper(input logic [7:0] c);
        logic [7:0] r;
        if ((c >= ASCII_LC_A) && (c <= ASCII_LC_Z)) begin
            r = c - ASCII_CASE_OFS;
        end else begin
            r = c;
        end
        return r;
    endfunction

    function automatic logic is_upper(input logic [7:0] c);
        return (c >= ASCII_UC_A) && (c <= ASCII_UC_Z);
    endfunction

endpackage

// File: rtl/wordle_scorer.sv
// Scoring datapath: one cycle marks greens, then one cycle per position hunts
// for a yellow among still-unused target letters, left to right.
module wordle_scorer
    import wordle_pkg::*;
#(
    parameter int WORD_LEN = 5
) (
    input  logic                    Clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    clear,
    input  logic [8*WORD_LEN-1:0]   guess,
    input  logic [8*WORD_LEN-1:0]   target,
    output logic [2*WORD_LEN-1:0]   score,
    output logic                    done
);

    localparam logic [2:0] LAST_IDX = 3'(WORD_LEN - 1);
    localparam logic [WORD_LEN-1:0] ONE_W = {{(WORD_LEN-1){1'b0}}, 1'b1};

    logic [2*WORD_LEN-1:0] score_q, score_d;
    logic [WORD_LEN-1:0]   used_q, used_d;
    logic [2:0]            idx_q, idx_d;
    logic                  busy_q, busy_d;

    logic [7:0]            cur_letter_s;
    logic [1:0]            cur_score_s;
    logic [WORD_LEN-1:0]   match_s;
    logic [WORD_LEN-1:0]   pick_s;
    logic                  done_s;

    // Next-state logic for the green pass and the per-position yellow search.
    always_comb begin
        score_d      = score_q;
        used_d       = used_q;
        idx_d        = idx_q;
        busy_d       = busy_q;
        done_s       = busy_q && (idx_q == LAST_IDX);
        cur_letter_s = guess[8*(WORD_LEN-1-int'(idx_q)) +: 8];
        cur_score_s  = score_q[2*(WORD_LEN-1-int'(idx_q)) +: 2];
        for (int j = 0; j < WORD_LEN; j++) begin
            match_s[j] = !used_q[j] && (target[8*(WORD_LEN-1-j) +: 8] == cur_letter_s);
        end
        // Isolate the lowest set bit: lowest-numbered unused matching position.
        pick_s = match_s & (~match_s + ONE_W);

        if (clear) begin
            score_d = '0;
            used_d  = '0;
            idx_d   = 3'd0;
            busy_d  = 1'b0;
        end else if (start) begin
            for (int p = 0; p < WORD_LEN; p++) begin
                if (guess[8*(WORD_LEN-1-p) +: 8] == target[8*(WORD_LEN-1-p) +: 8]) begin
                    score_d[2*(WORD_LEN-1-p) +: 2] = SC_GREEN;
                    used_d[p]                      = 1'b1;
                end else begin
                    score_d[2*(WORD_LEN-1-p) +: 2] = SC_ABSENT;
                    used_d[p]                      = 1'b0;
                end
            end
            idx_d  = 3'd0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if ((cur_score_s != SC_GREEN) && (|match_s)) begin
                used_d = used_q | pick_s;
                score_d[2*(WORD_LEN-1-int'(idx_q)) +: 2] = SC_YELLOW;
            end else begin
                used_d = used_q;
            end
            if (done_s) begin
                busy_d = 1'b0;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end else begin
            busy_d = 1'b0;
        end
    end

    // Scorer state registers.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            score_q <= '0;
            used_q  <= '0;
            idx_q   <= 3'd0;
            busy_q  <= 1'b0;
        end else begin
            score_q <= score_d;
            used_q  <= used_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
        end
    end

    assign score = score_q;
    assign done  = done_s;

endmodule

// File: rtl/wordle_engine.sv
// Wordle game engine: handshaked letter entry with backspace and submit,
// guess scoring via wordle_scorer, and win/lose tracking.
module wordle_engine
    import wordle_pkg::*;
#(
    parameter int WORD_LEN    = 5,
    parameter int MAX_GUESSES = 6
) (
    input  logic                    Clk,
    input  logic                    reset,
    input  logic                    Start,
    input  logic                    Ack,
    input  logic [8*WORD_LEN-1:0]   target,
    input  logic                    letter_valid,
    input  logic [7:0]              letter_in,
    input  logic                    backspace,
    input  logic                    enter,
    output logic [8*WORD_LEN-1:0]   guess_buf,
    output logic [3:0]              letter_count,
    output logic [3:0]              guess_num,
    output logic [2:0]              state_code,
    output logic [2*WORD_LEN-1:0]   score,
    output logic                    score_valid,
    output logic                    win,
    output logic                    lose
);

    localparam logic [3:0]            WL_CNT    = 4'(WORD_LEN);
    localparam logic [3:0]            MAX_CNT   = 4'(MAX_GUESSES);
    localparam logic [2*WORD_LEN-1:0] ALL_GREEN = {WORD_LEN{SC_GREEN}};

    state_t                state_q, state_d;
    logic [8*WORD_LEN-1:0] target_q, target_d;
    logic [8*WORD_LEN-1:0] guess_buf_q, guess_buf_d;
    logic [3:0]            letter_count_q, letter_count_d;
    logic [3:0]            guess_num_q, guess_num_d;
    logic                  score_valid_q, score_valid_d;
    logic                  win_q, win_d;
    logic                  lose_q, lose_d;

    logic                  scr_start_s;
    logic                  scr_clear_s;
    logic                  scr_done_s;
    logic [2*WORD_LEN-1:0] scr_score_s;
    logic [7:0]            key_s;

    wordle_scorer #(
        .WORD_LEN (WORD_LEN)
    ) u_scorer (
        .Clk    (Clk),
        .reset  (reset),
        .start  (scr_start_s),
        .clear  (scr_clear_s),
        .guess  (guess_buf_q),
        .target (target_q),
        .score  (scr_score_s),
        .done   (scr_done_s)
    );

    // Game FSM and entry-buffer next-state logic.
    always_comb begin
        state_d        = state_q;
        target_d       = target_q;
        guess_buf_d    = guess_buf_q;
        letter_count_d = letter_count_q;
        guess_num_d    = guess_num_q;
        score_valid_d  = score_valid_q;
        win_d          = win_q;
        lose_d         = lose_q;
        scr_start_s    = (state_q == ST_SCORE_G);
        scr_clear_s    = 1'b0;
        key_s          = fold_upper(letter_in);

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    target_d       = target;
                    guess_buf_d    = '0;
                    letter_count_d = 4'd0;
                    guess_num_d    = 4'd0;
                    scr_clear_s    = 1'b1;
                    state_d        = ST_ENTRY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            // One action per cycle: enter beats backspace beats a letter.
            ST_ENTRY: begin
                if (enter) begin
                    if (letter_count_q == WL_CNT) begin
                        state_d = ST_SCORE_G;
                    end else begin
                        state_d = ST_ENTRY;
                    end
                end else if (backspace) begin
                    if (letter_count_q != 4'd0) begin
                        guess_buf_d[8*(WORD_LEN-int'(letter_count_q)) +: 8] = 8'h00;
                        letter_count_d = letter_count_q - 4'd1;
                    end else begin
                        letter_count_d = letter_count_q;
                    end
                end else if (letter_valid) begin
                    if ((letter_count_q < WL_CNT) && is_upper(key_s)) begin
                        guess_buf_d[8*(WORD_LEN-1-int'(letter_count_q)) +: 8] = key_s;
                        letter_count_d = letter_count_q + 4'd1;
                    end else begin
                        letter_count_d = letter_count_q;
                    end
                end else begin
                    state_d = ST_ENTRY;
                end
            end
            ST_SCORE_G: begin
                state_d = ST_SCORE_Y;
            end
            ST_SCORE_Y: begin
                if (scr_done_s) begin
                    guess_num_d   = guess_num_q + 4'd1;
                    score_valid_d = 1'b1;
                    state_d       = ST_RESULT;
                end else begin
                    state_d = ST_SCORE_Y;
                end
            end
            ST_RESULT: begin
                if (Ack) begin
                    score_valid_d = 1'b0;
                    if (scr_score_s == ALL_GREEN) begin
                        win_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (guess_num_q == MAX_CNT) begin
                        lose_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        guess_buf_d    = '0;
                        letter_count_d = 4'd0;
                        scr_clear_s    = 1'b1;
                        state_d        = ST_ENTRY;
                    end
                end else begin
                    state_d = ST_RESULT;
                end
            end
            ST_DONE: begin
                if (Ack) begin
                    win_d   = 1'b0;
                    lose_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Engine state and registered outputs.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            target_q       <= '0;
            guess_buf_q    <= '0;
            letter_count_q <= 4'd0;
            guess_num_q    <= 4'd0;
            score_valid_q  <= 1'b0;
            win_q          <= 1'b0;
            lose_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            target_q       <= target_d;
            guess_buf_q    <= guess_buf_d;
            letter_count_q <= letter_count_d;
            guess_num_q    <= guess_num_d;
            score_valid_q  <= score_valid_d;
            win_q          <= win_d;
            lose_q         <= lose_d;
        end
    end

    assign guess_buf    = guess_buf_q;
    assign letter_count = letter_count_q;
    assign guess_num    = guess_num_q;
    assign state_code   = state_q;
    assign score        = scr_score_s;
    assign score_valid  = score_valid_q;
    assign win          = win_q;
    assign lose         = lose_q;

endmodule
